// File: rtl/board_tx_pkg.sv
// Shared types and constants for the board frame serial transmitter.
// Optional build macro: BOARD_TX_PARITY_EN (adds an even-parity bit after bit 0).
package board_tx_pkg;

  localparam int BOARD_TX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT_LO = 2'd1,
    ST_SHIFT_HI = 2'd2,
    ST_LATCH    = 2'd3
  } tx_state_e;

  // Busy length of one frame: two half-periods per bit plus the latch half-period.
  function automatic int frame_cycles(input int bits, input int clk_div);
    return (2 * bits + 1) * clk_div;
  endfunction

endpackage

// File: rtl/board_tx_phase_cnt.sv
// Serial-clock half-period counter: counts 0..CLK_DIV-1, flags the last cycle.
// Optional build macro: BOARD_TX_PARITY_EN (no effect on this block).
module board_tx_phase_cnt #(
  parameter  int CLK_DIV = 2,
  localparam int PH_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic            clka,
  input  logic            restart,
  input  logic            i_clear,
  output logic [PH_W-1:0] o_phase,
  output logic            o_phase_end
);

  logic [PH_W-1:0] r_cnt;

  assign o_phase_end = (r_cnt == PH_W'(CLK_DIV - 1));
  assign o_phase     = r_cnt;

  // NOTE: reset is synchronous, so it is just the highest-priority branch inside the clocked block.
  always_ff @(posedge clka) begin
    if (restart || i_clear) begin
      r_cnt <= '0;
    end else if (o_phase_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/board_serial_tx.sv
// Snapshots the board frame and shifts it MSB-first with a divided serial clock and latch strobe.
// Optional build macro: BOARD_TX_PARITY_EN (even-parity bit sent after bit 0).
module board_serial_tx
  import board_tx_pkg::*;
#(
  parameter int BOARD_W = BOARD_TX_W,
  parameter int CLK_DIV = 2
) (
  input  logic               clka,
  input  logic               restart,
  input  logic [BOARD_W-1:0] board_in,
  input  logic               send_req,
  output logic               ser_clk,
  output logic               ser_data,
  output logic               ser_latch,
  output logic               busy,
  output logic               frame_done
);

`ifdef BOARD_TX_PARITY_EN
  localparam int FRAME_BITS = BOARD_W + 1;
`else
  localparam int FRAME_BITS = BOARD_W;
`endif
  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  tx_state_e             r_state, w_state_nxt;
  logic [FRAME_BITS-1:0] r_shreg, w_shreg_nxt, w_snapshot;
  logic [CNT_W-1:0]      r_bit_cnt, w_bit_cnt_nxt;
  logic                  r_pending, w_pending_nxt;
  logic                  r_ser_clk, r_ser_data, r_ser_latch, r_busy, r_frame_done;
  logic                  w_ser_data_nxt, w_frame_done_nxt;
  logic [PH_W-1:0]       w_phase;
  logic                  w_phase_end;

`ifdef BOARD_TX_PARITY_EN
  assign w_snapshot = {board_in, ^board_in};
`else
  assign w_snapshot = board_in;
`endif

  board_tx_phase_cnt #(.CLK_DIV(CLK_DIV)) u_phase (
    .clka        (clka),
    .restart     (restart),
    .i_clear     (r_state == ST_IDLE),
    .o_phase     (w_phase),
    .o_phase_end (w_phase_end)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    w_pending_nxt = r_pending;
    if (r_state != ST_IDLE && send_req) w_pending_nxt = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        if (send_req) begin
          w_state_nxt   = ST_SHIFT_LO;
          w_shreg_nxt   = w_snapshot;
          w_bit_cnt_nxt = '0;
        end
      end
      ST_SHIFT_LO: begin
        if (w_phase_end) w_state_nxt = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        if (w_phase_end) begin
          w_shreg_nxt   = {r_shreg[FRAME_BITS-2:0], 1'b0};
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          w_state_nxt   = (r_bit_cnt == CNT_W'(FRAME_BITS - 1)) ? ST_LATCH : ST_SHIFT_LO;
        end
      end
      ST_LATCH: begin
        // A request landing on the closing edge counts as pending so it is never lost.
        if (w_phase_end) begin
          if (r_pending || send_req) begin
            w_state_nxt   = ST_SHIFT_LO;
            w_shreg_nxt   = w_snapshot;
            w_bit_cnt_nxt = '0;
            w_pending_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_ser_data_nxt = (w_state_nxt == ST_SHIFT_LO || w_state_nxt == ST_SHIFT_HI) ?
                     w_shreg_nxt[FRAME_BITS-1] : 1'b0;
    w_frame_done_nxt = (w_state_nxt == ST_LATCH) &&
                       ((CLK_DIV == 1) || (r_state == ST_LATCH && int'(w_phase) == CLK_DIV - 2));
  end

  // NOTE: state and outputs use non-blocking assignments so all registers update together.
  always_ff @(posedge clka) begin
    if (restart) begin
      r_state      <= ST_IDLE;
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_pending    <= 1'b0;
      r_ser_clk    <= 1'b0;
      r_ser_data   <= 1'b0;
      r_ser_latch  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_pending    <= w_pending_nxt;
      r_ser_clk    <= (w_state_nxt == ST_SHIFT_HI);
      r_ser_data   <= w_ser_data_nxt;
      r_ser_latch  <= (w_state_nxt == ST_LATCH);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign ser_clk    = r_ser_clk;
  assign ser_data   = r_ser_data;
  assign ser_latch  = r_ser_latch;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_board_serial_tx.sv
// Self-checking bench: two transmitters (CLK_DIV=2 and CLK_DIV=1) against a bit-list reference.
// Honors BOARD_TX_PARITY_EN when it is defined for the build.
module tb_board_serial_tx;

  localparam int W = 32;
`ifdef BOARD_TX_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  localparam int LEN_A = (2 * NB + 1) * 2;
  localparam int LEN_B = (2 * NB + 1) * 1;

  logic         clka = 1'b0;
  logic         restart;
  logic [W-1:0] a_board, b_board;
  logic         a_req, b_req;
  logic         a_ser_clk, a_ser_data, a_ser_latch, a_busy, a_frame_done;
  logic         b_ser_clk, b_ser_data, b_ser_latch, b_busy, b_frame_done;

  always #5 clka = ~clka;

  board_serial_tx #(.BOARD_W(W), .CLK_DIV(2)) dut_a (
    .clka(clka), .restart(restart), .board_in(a_board), .send_req(a_req),
    .ser_clk(a_ser_clk), .ser_data(a_ser_data), .ser_latch(a_ser_latch),
    .busy(a_busy), .frame_done(a_frame_done)
  );

  board_serial_tx #(.BOARD_W(W), .CLK_DIV(1)) dut_b (
    .clka(clka), .restart(restart), .board_in(b_board), .send_req(b_req),
    .ser_clk(b_ser_clk), .ser_data(b_ser_data), .ser_latch(b_ser_latch),
    .busy(b_busy), .frame_done(b_frame_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Line monitor: bits captured at every ser_clk rise plus per-window event counts.
  logic mon_clr;
  logic a_bits[$];
  logic b_bits[$];
  int   a_busy_cnt, a_latch_cnt, a_done_cnt, a_done_bad, a_runs, a_unstable;
  int   b_busy_cnt, b_latch_cnt, b_done_cnt, b_toggle_err;
  logic a_prev_clk, a_prev_data, a_prev_busy;
  logic b_prev_clk, b_prev_busy, b_prev_latch;

  always @(negedge clka) begin
    if (mon_clr) begin
      a_bits.delete();
      b_bits.delete();
      a_busy_cnt <= 0; a_latch_cnt <= 0; a_done_cnt <= 0; a_done_bad <= 0;
      a_runs <= 0; a_unstable <= 0;
      b_busy_cnt <= 0; b_latch_cnt <= 0; b_done_cnt <= 0; b_toggle_err <= 0;
    end else begin
      if (a_ser_clk && !a_prev_clk) a_bits.push_back(a_ser_data);
      if (a_ser_clk && a_prev_clk && a_ser_data != a_prev_data) a_unstable <= a_unstable + 1;
      if (a_busy) a_busy_cnt <= a_busy_cnt + 1;
      if (a_busy && !a_prev_busy) a_runs <= a_runs + 1;
      if (a_ser_latch) a_latch_cnt <= a_latch_cnt + 1;
      if (a_frame_done) a_done_cnt <= a_done_cnt + 1;
      if (a_frame_done && !a_ser_latch) a_done_bad <= a_done_bad + 1;
      if (b_ser_clk && !b_prev_clk) b_bits.push_back(b_ser_data);
      if (b_busy) b_busy_cnt <= b_busy_cnt + 1;
      if (b_ser_latch) b_latch_cnt <= b_latch_cnt + 1;
      if (b_frame_done) b_done_cnt <= b_done_cnt + 1;
      if (b_busy && !b_ser_latch && b_prev_busy && !b_prev_latch && b_ser_clk == b_prev_clk)
        b_toggle_err <= b_toggle_err + 1;
    end
    a_prev_clk   <= a_ser_clk;
    a_prev_data  <= a_ser_data;
    a_prev_busy  <= a_busy;
    b_prev_clk   <= b_ser_clk;
    b_prev_busy  <= b_busy;
    b_prev_latch <= b_ser_latch;
  end

  // Reference frame: the word MSB-first, then its even parity when enabled.
  function automatic logic [63:0] expw(input logic [31:0] v);
`ifdef BOARD_TX_PARITY_EN
    return {31'b0, v, ^v};
`else
    return {32'b0, v};
`endif
  endfunction

  function automatic logic [63:0] pack_a(input int start);
    logic [63:0] r = '0;
    for (int i = 0; i < NB; i++)
      r = {r[62:0], (start + i < a_bits.size()) ? a_bits[start + i] : 1'b0};
    return r;
  endfunction

  function automatic logic [63:0] pack_b(input int start);
    logic [63:0] r = '0;
    for (int i = 0; i < NB; i++)
      r = {r[62:0], (start + i < b_bits.size()) ? b_bits[start + i] : 1'b0};
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clka);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clka);
    #1 mon_clr = 1'b0;
  endtask

  task automatic pulse_a();
    a_req = 1'b1; tick(1); a_req = 1'b0;
  endtask

  task automatic pulse_b();
    b_req = 1'b1; tick(1); b_req = 1'b0;
  endtask

  task automatic wait_a_idle(input string tag, input int max);
    int n = 0;
    while (a_busy && n < max) begin @(negedge clka); n++; end
    check(tag, 64'(n < max), 64'd1);
    tick(3);
  endtask

  task automatic wait_b_idle(input string tag, input int max);
    int n = 0;
    while (b_busy && n < max) begin @(negedge clka); n++; end
    check(tag, 64'(n < max), 64'd1);
    tick(3);
  endtask

  task automatic frame_a(input string tag, input logic [31:0] v);
    clear_mon();
    a_board = v;
    pulse_a();
    wait_a_idle({tag, "_to"}, 400);
    check({tag, "_nbits"}, 64'(a_bits.size()), 64'(NB));
    check({tag, "_bits"}, pack_a(0), expw(v));
    check({tag, "_busy"}, 64'(a_busy_cnt), 64'(LEN_A));
  endtask

  logic [31:0] v0, v1;
`ifdef BOARD_TX_PARITY_EN
  logic [31:0] par_word [2] = '{32'h0000_0001, 32'h0000_0003};
  logic        par_bit  [2] = '{1'b1, 1'b0};
`endif

  initial begin
    restart = 1'b1; a_req = 1'b0; b_req = 1'b0;
    a_board = '0; b_board = '0; mon_clr = 1'b1;
    tick(3);
    restart = 1'b0;
    @(negedge clka);
    check("rst_ser_clk", 64'(a_ser_clk), 64'd0);
    check("rst_ser_data", 64'(a_ser_data), 64'd0);
    check("rst_ser_latch", 64'(a_ser_latch), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_frame_done", 64'(a_frame_done), 64'd0);
    tick(2);

    // Single frame; board_in disturbed mid-frame must not leak into it.
    clear_mon();
    a_board = 32'hA5A5_0F0F;
    pulse_a();
    @(negedge clka);
    check("t1_busy_first", 64'(a_busy), 64'd1);
    check("t1_msb_first", 64'(a_ser_data), 64'd1);
    tick(40);
    a_board = 32'hFFFF_FFFF;
    wait_a_idle("t1_to", 400);
    check("t1_nbits", 64'(a_bits.size()), 64'(NB));
    check("t1_bits", pack_a(0), expw(32'hA5A5_0F0F));
    check("t1_latch", 64'(a_latch_cnt), 64'd2);
    check("t1_done", 64'(a_done_cnt), 64'd1);
    check("t1_done_in_latch", 64'(a_done_bad), 64'd0);
    check("t1_busy", 64'(a_busy_cnt), 64'(LEN_A));
    check("t1_stable", 64'(a_unstable), 64'd0);

    // Two requests while busy collapse into one gapless follow-on frame.
    clear_mon();
    v0 = $urandom;
    a_board = v0;
    pulse_a();
    tick(20); pulse_a();
    tick(40); pulse_a();
    tick(30); a_board = 32'h1234_5678;
    wait_a_idle("t2_to", 800);
    check("t2_nbits", 64'(a_bits.size()), 64'(2 * NB));
    check("t2_frame0", pack_a(0), expw(v0));
    check("t2_frame1", pack_a(NB), expw(32'h1234_5678));
    check("t2_busy", 64'(a_busy_cnt), 64'(2 * LEN_A));
    check("t2_busy_runs", 64'(a_runs), 64'd1);
    check("t2_done", 64'(a_done_cnt), 64'd2);
    check("t2_latch", 64'(a_latch_cnt), 64'd4);

    // Abort after bit 10, then a clean frame.
    begin
      int n = 0;
      clear_mon();
      a_board = $urandom;
      pulse_a();
      while (a_bits.size() < 11 && n < 300) begin @(negedge clka); n++; end
      check("t3_reach_bit10", 64'(n < 300), 64'd1);
    end
    tick(1);
    restart = 1'b1; tick(1); restart = 1'b0;
    @(negedge clka);
    check("t3_outs_zero",
          64'({a_ser_clk, a_ser_data, a_ser_latch, a_busy, a_frame_done}), 64'd0);
    tick(150);
    check("t3_no_latch", 64'(a_latch_cnt), 64'd0);
    check("t3_no_done", 64'(a_done_cnt), 64'd0);
    frame_a("t3_after", $urandom);

    for (int i = 0; i < 3; i++) frame_a($sformatf("rnd%0d", i), $urandom);

`ifdef BOARD_TX_PARITY_EN
    for (int i = 0; i < 2; i++) begin
      frame_a($sformatf("par%0d", i), par_word[i]);
      check($sformatf("par%0d_bit33", i), 64'(a_bits[W]), 64'(par_bit[i]));
    end
`endif

    // Divide-by-one: serial clock toggles every shift cycle.
    clear_mon();
    b_board = 32'h8000_0001;
    pulse_b();
    wait_b_idle("d1_to", 200);
    check("d1_nbits", 64'(b_bits.size()), 64'(NB));
    check("d1_bits", pack_b(0), expw(32'h8000_0001));
    check("d1_first_bit", 64'(b_bits[0]), 64'd1);
    check("d1_last_bit", 64'(b_bits[W-1]), 64'd1);
    check("d1_toggle", 64'(b_toggle_err), 64'd0);
    check("d1_busy", 64'(b_busy_cnt), 64'(LEN_B));
    check("d1_latch", 64'(b_latch_cnt), 64'd1);
    check("d1_done", 64'(b_done_cnt), 64'd1);

    clear_mon();
    v1 = $urandom;
    b_board = v1;
    pulse_b();
    wait_b_idle("d1r_to", 200);
    check("d1r_bits", pack_b(0), expw(v1));
    check("d1r_busy", 64'(b_busy_cnt), 64'(LEN_B));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
